aud_dac_arbiter: RTL and testbench

//  Shares the WM8978 DAC sample path (dac_data/tx_done of wm8978_ctrl) among N_SRC

---
 rtl/aud_dac_arbiter_if.sv | 45 ++++
 rtl/aud_dac_arbiter.sv | 229 ++++++++++++++++++++++
 tb/tb_aud_dac_arbiter.sv | 248 ++++++++++++++++++++++++
 3 files changed

// File: rtl/aud_dac_arbiter_if.sv
// ----------------------------------------------------------------------------
// aud_dac_arbiter_if
//   Bundles the source-side and DAC-side signals of aud_dac_arbiter so that
//   the arbiter and its environment connect through one port.
//
//   Signals (N_SRC = number of audio sources):
//     tx_done      1-cycle pulse from wm8978_ctrl, current dac_data consumed
//     mute         level, forces silent output
//     src_req      N_SRC   level request per source
//     src_valid    N_SRC   src_data[i] holds a sample
//     src_data     32*N_SRC  sample i at [32i+31:32i], L=[31:16], R=[15:0]
//     src_ready    N_SRC   1-cycle pop pulse to the granted source
//     dac_data     32      word presented to wm8978_ctrl.dac_data
//     grant        N_SRC   one-hot current owner, 0 = none
//     underrun     1       pulse, granted source not valid at tx_done
//     switch_busy  1       high while a soft switch is in progress
//
//   Modports:
//     master  environment side (sources + DAC controller)
//     slave   arbiter side
// ----------------------------------------------------------------------------
interface aud_dac_arbiter_if #(
    parameter int N_SRC = 3
);
    logic                 tx_done;
    logic                 mute;
    logic [N_SRC-1:0]     src_req;
    logic [N_SRC-1:0]     src_valid;
    logic [32*N_SRC-1:0]  src_data;
    logic [N_SRC-1:0]     src_ready;
    logic [31:0]          dac_data;
    logic [N_SRC-1:0]     grant;
    logic                 underrun;
    logic                 switch_busy;

    modport master (
        output tx_done, mute, src_req, src_valid, src_data,
        input  src_ready, dac_data, grant, underrun, switch_busy
    );

    modport slave (
        input  tx_done, mute, src_req, src_valid, src_data,
        output src_ready, dac_data, grant, underrun, switch_busy
    );
endinterface

// File: rtl/aud_dac_arbiter.sv
// ----------------------------------------------------------------------------
// aud_dac_arbiter
//   Shares the WM8978 DAC sample path among N_SRC audio sources with fixed
//   priority (source 0 highest). Ownership only changes on a frame boundary
//   (tx_done); the next 32-bit stereo word is registered and held for the
//   whole following frame.
//
//   Parameters:
//     N_SRC      number of requesters (1..8)
//     RAMP_LOG2  soft-switch ramp length is 2**RAMP_LOG2 frames
//
//   Ports:
//     sys_clk    system clock
//     sys_rst_n  asynchronous active-low reset
//     bus        aud_dac_arbiter_if.slave (see interface file for signals)
//
//   Build option:
//     SOFT_SWITCH_EN  when defined, owner changes fade the old source down
//                     and the new source up over 2**RAMP_LOG2 frames
//                     (RAMP_DN / RAMP_UP states, switch_busy high meanwhile).
//                     When undefined, owner changes are immediate and
//                     switch_busy is tied low.
// ----------------------------------------------------------------------------
module aud_dac_arbiter #(
    parameter int N_SRC     = 3,
    parameter int RAMP_LOG2 = 4
) (
    input  logic             sys_clk,
    input  logic             sys_rst_n,
    aud_dac_arbiter_if.slave bus
);

    typedef enum logic [1:0] {IDLE, PLAY, RAMP_DN, RAMP_UP} state_e;

    if (N_SRC < 1 || N_SRC > 8 || RAMP_LOG2 < 0) begin : g_param_check
        $error("aud_dac_arbiter: N_SRC must be 1..8 and RAMP_LOG2 >= 0");
    end

    state_e              state_q, state_d;
    logic [N_SRC-1:0]    grant_q, grant_d;
    logic [N_SRC-1:0]    ready_q, ready_d;
    logic [31:0]         dac_q, dac_d;
    logic                underrun_q, underrun_d;

    logic                tgt_vld;
    logic [N_SRC-1:0]    tgt_oh;
    logic [N_SRC-1:0]    take_oh;
    logic [31:0]         take_word;
    logic                take_valid;

    // Selects the word of the (one-hot) chosen source; all-zero selector gives 0.
    function automatic logic [31:0] pick_word(input logic [N_SRC-1:0]   oh,
                                              input logic [32*N_SRC-1:0] data);
        logic [31:0] w;
        w = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (oh[i]) w = w | data[32*i +: 32];
        end
        return w;
    endfunction

`ifdef SOFT_SWITCH_EN
    localparam int               LVL_W    = RAMP_LOG2 + 1;
    localparam int               PROD_W   = LVL_W + 17;
    localparam logic [LVL_W-1:0] LVL_ONE  = LVL_W'(1);
    localparam logic [LVL_W-1:0] LVL_LAST = (LVL_W'(1) << RAMP_LOG2) - LVL_ONE;

    logic [LVL_W-1:0] lvl_q, lvl_d, take_lvl;
    logic             own_req;

    assign own_req = |(grant_q & bus.src_req);

    // (sample * lvl) >>> RAMP_LOG2 on one signed channel; full level is bit-exact.
    function automatic logic [15:0] scale_ch(input logic [15:0]      s,
                                             input logic [LVL_W-1:0] lvl);
        logic signed [PROD_W-1:0] a, b, p;
        a = PROD_W'($signed(s));
        b = PROD_W'($signed({1'b0, lvl}));
        p = a * b;
        return p[RAMP_LOG2 +: 16];
    endfunction
`endif

    // Highest-priority requester, sampled only where tx_done is high.
    always_comb begin
        tgt_vld = 1'b0;
        tgt_oh  = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (bus.src_req[i] && !tgt_vld) begin
                tgt_vld   = 1'b1;
                tgt_oh[i] = 1'b1;
            end
        end
    end

    // State register together with the registered outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q    <= IDLE;
            grant_q    <= '0;
            ready_q    <= '0;
            dac_q      <= '0;
            underrun_q <= 1'b0;
`ifdef SOFT_SWITCH_EN
            lvl_q      <= '0;
`endif
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ready_q    <= ready_d;
            dac_q      <= dac_d;
            underrun_q <= underrun_d;
`ifdef SOFT_SWITCH_EN
            lvl_q      <= lvl_d;
`endif
        end
    end

    // Next-state logic: decides the owner, which source (if any) is consumed
    // this frame and, with soft switching, the fade level.
    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        take_oh = '0;
`ifdef SOFT_SWITCH_EN
        lvl_d    = lvl_q;
        take_lvl = lvl_q;
`endif
        if (bus.tx_done) begin
            unique case (state_q)
                IDLE: begin
                    // A fresh owner is only granted here; its first sample
                    // is taken at the following tx_done.
                    if (tgt_vld) begin
                        grant_d = tgt_oh;
`ifdef SOFT_SWITCH_EN
                        lvl_d   = '0;
                        state_d = RAMP_UP;
`else
                        state_d = PLAY;
`endif
                    end
                end
                PLAY: begin
                    if (tgt_oh == grant_q) begin
                        take_oh = grant_q;
                    end else begin
`ifdef SOFT_SWITCH_EN
                        // Start fading the current owner; if it already
                        // dropped its request, go silent straight away.
                        state_d = RAMP_DN;
                        if (own_req) begin
                            lvl_d    = lvl_q - LVL_ONE;
                            take_lvl = lvl_q - LVL_ONE;
                            take_oh  = grant_q;
                        end else begin
                            lvl_d = '0;
                        end
`else
                        // Hard switch: the new owner supplies this frame.
                        grant_d = tgt_oh;
                        take_oh = tgt_oh;
                        if (!tgt_vld) state_d = IDLE;
`endif
                    end
                end
`ifdef SOFT_SWITCH_EN
                RAMP_DN: begin
                    if (lvl_q == '0) begin
                        grant_d = tgt_oh;
                        state_d = tgt_vld ? RAMP_UP : IDLE;
                    end else if (!own_req) begin
                        lvl_d = '0;
                    end else begin
                        lvl_d    = lvl_q - LVL_ONE;
                        take_lvl = lvl_q - LVL_ONE;
                        take_oh  = grant_q;
                    end
                end
                RAMP_UP: begin
                    // New requests are ignored until the ramp completes.
                    take_oh = grant_q;
                    lvl_d   = lvl_q + LVL_ONE;
                    if (lvl_q == LVL_LAST) state_d = PLAY;
                end
`endif
                default: state_d = IDLE;
            endcase
        end
    end

    // Output datapath: pop the consumed source, flag underrun, build the word.
    always_comb begin
        take_word  = pick_word(take_oh, bus.src_data);
        take_valid = |(take_oh & bus.src_valid);
        ready_d    = '0;
        underrun_d = 1'b0;
        dac_d      = dac_q;
        if (bus.tx_done) begin
            dac_d = '0;
            if (|take_oh) begin
                if (take_valid) begin
                    ready_d = take_oh;
                    if (!bus.mute) begin
`ifdef SOFT_SWITCH_EN
                        dac_d = {scale_ch(take_word[31:16], take_lvl),
                                 scale_ch(take_word[15:0],  take_lvl)};
`else
                        dac_d = take_word;
`endif
                    end
                end else begin
                    underrun_d = 1'b1;
                end
            end
        end
    end

    assign bus.dac_data  = dac_q;
    assign bus.grant     = grant_q;
    assign bus.src_ready = ready_q;
    assign bus.underrun  = underrun_q;
`ifdef SOFT_SWITCH_EN
    assign bus.switch_busy = (state_q == RAMP_DN) || (state_q == RAMP_UP);
`else
    assign bus.switch_busy = 1'b0;
`endif

endmodule

// File: tb/tb_aud_dac_arbiter.sv
// ----------------------------------------------------------------------------
// tb_aud_dac_arbiter
//   Self-checking bench for aud_dac_arbiter (N_SRC=3, RAMP_LOG2=2).
//   Each frame record holds the inputs applied with a tx_done pulse and the
//   outputs expected one clock later. Expected outputs are queued when the
//   frame is driven and compared when the DUT has produced them. The cycle
//   after that, the pulses must be gone and dac_data must hold.
//   Hand-written sequences cover reset, an ignored request pulse between
//   frames and an asynchronous reset in the middle of a frame.
//   The frame table follows the SOFT_SWITCH_EN build option.
// ----------------------------------------------------------------------------
module tb_aud_dac_arbiter;

    localparam int N   = 3;
    localparam int RL2 = 2;

`ifdef SOFT_SWITCH_EN
    localparam logic SOFT = 1'b1;
`else
    localparam logic SOFT = 1'b0;
`endif

    localparam logic [31:0] S0 = 32'h5555_0001;
    localparam logic [31:0] S1 = 32'h1234_ABCD;
    localparam logic [31:0] S2 = 32'h0BAD_F00D;
    localparam logic [31:0] M1 = 32'h7FFF_8000;
    localparam logic [95:0] DATA_A = {S2, S1, S0};
    localparam logic [95:0] DATA_M = {S2, M1, S0};
    localparam logic [95:0] DATA_S = {32'h0000_0000, 32'h4000_C000, 32'h0100_0100};

    typedef struct packed {
        logic [7:0]  tag;
        logic [31:0] dac;
        logic [2:0]  grant;
        logic [2:0]  ready;
        logic        underrun;
        logic        busy;
    } exp_t;

    typedef struct packed {
        logic        mute;
        logic [2:0]  req;
        logic [2:0]  valid;
        logic [95:0] data;
        exp_t        exp;
    } vec_t;

    logic sys_clk = 1'b0;
    logic sys_rst_n;

    aud_dac_arbiter_if #(.N_SRC(N)) bus ();

    aud_dac_arbiter #(
        .N_SRC     (N),
        .RAMP_LOG2 (RL2)
    ) dut (
        .sys_clk   (sys_clk),
        .sys_rst_n (sys_rst_n),
        .bus       (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int          checkCnt = 0;
    int          passCnt  = 0;
    exp_t        expQ[$];
    vec_t        vecs[$];
    exp_t        rstExp;
    logic        txDly;
    logic        txDly2;
    logic [31:0] lastDac = '0;

    function automatic vec_t mkVec(input logic mute, input logic [2:0] req,
                                   input logic [2:0] valid, input logic [95:0] data,
                                   input logic [31:0] dac, input logic [2:0] grant,
                                   input logic [2:0] ready, input logic und,
                                   input logic busy);
        vec_t v;
        v.mute         = mute;
        v.req          = req;
        v.valid        = valid;
        v.data         = data;
        v.exp.tag      = '0;
        v.exp.dac      = dac;
        v.exp.grant    = grant;
        v.exp.ready    = ready;
        v.exp.underrun = und;
        v.exp.busy     = busy;
        return v;
    endfunction

    task automatic checkField(input string what, input int tag,
                              input logic [31:0] act, input logic [31:0] want);
        checkCnt++;
        if (act === want) passCnt++;
        else $display("[TB] FAIL %s (frame %0d): actual %h required %h", what, tag, act, want);
    endtask

    task automatic checkOutput(input exp_t e);
        checkField("dac_data",    int'(e.tag), bus.dac_data,            e.dac);
        checkField("grant",       int'(e.tag), 32'(bus.grant),          32'(e.grant));
        checkField("src_ready",   int'(e.tag), 32'(bus.src_ready),      32'(e.ready));
        checkField("underrun",    int'(e.tag), 32'(bus.underrun),       32'(e.underrun));
        checkField("switch_busy", int'(e.tag), 32'(bus.switch_busy),    32'(e.busy));
    endtask

    // Drive one frame: inputs plus a one-cycle tx_done, queue the expectation.
    task automatic applyStimulus(input vec_t v, input int idx);
        exp_t e;
        @(negedge sys_clk);
        bus.mute      = v.mute;
        bus.src_req   = v.req;
        bus.src_valid = v.valid;
        bus.src_data  = v.data;
        bus.tx_done   = 1'b1;
        e     = v.exp;
        e.tag = 8'(idx);
        expQ.push_back(e);
        @(negedge sys_clk);
        bus.tx_done = 1'b0;
        repeat (3) @(negedge sys_clk);
    endtask

    // Tracks which cycles follow a tx_done so the monitor knows when to compare.
    always @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            txDly  <= 1'b0;
            txDly2 <= 1'b0;
        end else begin
            txDly  <= bus.tx_done;
            txDly2 <= txDly;
        end
    end

    // Scoreboard monitor: compare the frame result, then check pulses ended.
    always @(negedge sys_clk) begin
        if (sys_rst_n && txDly) begin
            if (expQ.size() == 0) begin
                checkCnt++;
                $display("[TB] FAIL scoreboard underflow: actual 0 entries required 1");
            end else begin
                exp_t e;
                e = expQ.pop_front();
                checkOutput(e);
                lastDac = e.dac;
            end
        end
        if (sys_rst_n && txDly2) begin
            checkField("src_ready pulse end", 255, 32'(bus.src_ready), 32'd0);
            checkField("underrun pulse end",  255, 32'(bus.underrun),  32'd0);
            checkField("dac_data hold",       255, bus.dac_data,       lastDac);
        end
    end

    initial begin
`ifdef SOFT_SWITCH_EN
        // Ramp up src1 (0x4000_C000), preempt by src0, ramp down, switch.
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h0000_0000, 3'b010, 3'b000, 0, 1));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h0000_0000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h1000_F000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h2000_E000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h3000_D000, 3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_S, 32'h4000_C000, 3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h3000_D000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h2000_E000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h1000_F000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h0000_0000, 3'b010, 3'b010, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h0000_0000, 3'b001, 3'b000, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h0000_0000, 3'b001, 3'b001, 0, 1));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_S, 32'h0040_0040, 3'b001, 3'b001, 0, 1));
`else
        // Grant, play, preempt, underrun, req drop, mute, idle, simultaneous rise.
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_A, 32'h0000_0000, 3'b010, 3'b000, 0, 0));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_A, S1,            3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_A, S1,            3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b011, 3'b011, DATA_A, S0,            3'b001, 3'b001, 0, 0));
        vecs.push_back(mkVec(0, 3'b011, 3'b010, DATA_A, 32'h0000_0000, 3'b001, 3'b000, 1, 0));
        vecs.push_back(mkVec(0, 3'b010, 3'b010, DATA_A, S1,            3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(1, 3'b010, 3'b010, DATA_M, 32'h0000_0000, 3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(1, 3'b010, 3'b010, DATA_M, 32'h0000_0000, 3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b110, 3'b110, DATA_A, S1,            3'b010, 3'b010, 0, 0));
        vecs.push_back(mkVec(0, 3'b100, 3'b100, DATA_A, S2,            3'b100, 3'b100, 0, 0));
        vecs.push_back(mkVec(0, 3'b000, 3'b111, DATA_A, 32'h0000_0000, 3'b000, 3'b000, 0, 0));
        vecs.push_back(mkVec(0, 3'b000, 3'b000, DATA_A, 32'h0000_0000, 3'b000, 3'b000, 0, 0));
        vecs.push_back(mkVec(0, 3'b111, 3'b000, DATA_A, 32'h0000_0000, 3'b001, 3'b000, 0, 0));
        vecs.push_back(mkVec(0, 3'b111, 3'b000, DATA_A, 32'h0000_0000, 3'b001, 3'b000, 1, 0));
        vecs.push_back(mkVec(0, 3'b110, 3'b111, DATA_A, S1,            3'b010, 3'b010, 0, 0));
`endif

        // Reset held: a tx_done with a live request must leave everything at zero.
        sys_rst_n     = 1'b0;
        bus.tx_done   = 1'b0;
        bus.mute      = 1'b0;
        bus.src_req   = '0;
        bus.src_valid = '0;
        bus.src_data  = '0;
        repeat (2) @(negedge sys_clk);
        bus.src_req   = 3'b010;
        bus.src_valid = 3'b010;
        bus.src_data  = DATA_A;
        bus.tx_done   = 1'b1;
        @(negedge sys_clk);
        bus.tx_done   = 1'b0;
        rstExp        = '0;
        rstExp.tag    = 8'd200;
        checkOutput(rstExp);
        bus.src_req   = '0;
        bus.src_valid = '0;
        @(negedge sys_clk);
        sys_rst_n = 1'b1;

        // A request pulse between frames must not be remembered.
        @(negedge sys_clk);
        bus.src_req   = 3'b001;
        bus.src_valid = 3'b001;
        @(negedge sys_clk);
        bus.src_req   = 3'b000;
        applyStimulus(mkVec(0, 3'b000, 3'b001, DATA_A, 32'h0, 3'b000, 3'b000, 0, 0), 201);

        for (int i = 0; i < vecs.size(); i++) begin
            applyStimulus(vecs[i], i);
        end

        // Asynchronous reset shortly after a consuming edge.
        @(negedge sys_clk);
        bus.src_req   = 3'b011;
        bus.src_valid = 3'b011;
        bus.src_data  = DATA_A;
        bus.tx_done   = 1'b1;
        @(posedge sys_clk);
        #2;
        bus.tx_done = 1'b0;
        checkField("src_ready before async reset", 202, 32'(bus.src_ready), 32'(3'b001));
        sys_rst_n = 1'b0;
        #1;
        rstExp.tag = 8'd202;
        checkOutput(rstExp);
        repeat (2) @(negedge sys_clk);
        sys_rst_n = 1'b1;
        applyStimulus(mkVec(0, 3'b010, 3'b010, DATA_A, 32'h0, 3'b010, 3'b000, 0, SOFT), 203);

        repeat (3) @(negedge sys_clk);
        checkField("scoreboard drained", 204, 32'(expQ.size()), 32'd0);
        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule
